// File: rtl/fir_output_checker.sv
// Shadow model of the 4th-order FIR MAC filter: recomputes each output from the tapped
// sample stream, aligns it to the filter's pipeline latency and scores every compare.
module fir_output_checker #(
    parameter int FIR_order     = 4,
    parameter int Sample_size   = 6,
    parameter int weight_size   = 5,
    parameter int word_size_out = 2 * Sample_size + 2,
    parameter logic [weight_size-1:0] W0 = 1,
    parameter logic [weight_size-1:0] W1 = 2,
    parameter logic [weight_size-1:0] W2 = 3,
    parameter logic [weight_size-1:0] W3 = 4,
    parameter logic [weight_size-1:0] W4 = 5,
    parameter int PIPE_LATENCY  = 2,
    parameter int ERR_W         = 8,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Sample_size-1:0]   Sample_in,
    input  logic [word_size_out-1:0] FIR_out,
    input  logic                     check_en,
    output logic [word_size_out-1:0] expected_out,
    output logic                     mismatch,
    output logic [ERR_W-1:0]         error_count,
    output logic [15:0]              compare_count,
    output logic [1:0]               state
);

    localparam int TAPS     = FIR_order + 1;
    localparam int PW       = Sample_size + weight_size;
    localparam int STAGES   = PIPE_LATENCY - 1;
    localparam int WARM_END = FIR_order + PIPE_LATENCY;
    localparam int WC_W     = $clog2(WARM_END + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WARMUP = 2'b01,
        CHECK  = 2'b10,
        HALT   = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [Sample_size-1:0]   x     [TAPS];
    logic [word_size_out-1:0] align [STAGES];
    logic [word_size_out-1:0] sum;
    logic [WC_W-1:0]          wcnt;
    logic                     run;
    logic                     differ;
    logic                     do_compare;

    function automatic logic [weight_size-1:0] tap_weight(input int k);
        case (k)
            0:       return W0;
            1:       return W1;
            2:       return W2;
            3:       return W3;
            4:       return W4;
            default: return '0;
        endcase
    endfunction

    assign run        = (state_q != HALT);
    assign differ     = (FIR_out != expected_out);
    assign do_compare = (state_q == CHECK) && check_en;
    assign state      = state_q;

    // Full-width products; the sum of all taps fits word_size_out without overflow.
    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + word_size_out'(PW'(x[k]) * PW'(tap_weight(k)));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) x[k] <= '0;
            for (int i = 0; i < STAGES; i++) align[i] <= '0;
        end else if (run) begin
            x[0] <= Sample_in;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
            align[0] <= sum;
            for (int i = 1; i < STAGES; i++) align[i] <= align[i-1];
        end
    end

    assign expected_out = align[STAGES-1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (check_en) state_d = WARMUP;
            WARMUP: begin
                if (!check_en)                          state_d = IDLE;
                else if (wcnt == WC_W'(WARM_END - 1))   state_d = CHECK;
            end
            CHECK: begin
                if (!check_en)                          state_d = IDLE;
                else if (STOP_ON_ERROR && differ)       state_d = HALT;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt <= '0;
        end else if (state_q == WARMUP && check_en) begin
            wcnt <= wcnt + 1'b1;
        end else if (run) begin
            wcnt <= '0;
        end
    end

    // HALT performs no compares, so the pulse drops back to 0 while everything else holds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mismatch      <= 1'b0;
            error_count   <= '0;
            compare_count <= '0;
        end else begin
            mismatch <= do_compare && differ;
            if (do_compare && !(&compare_count)) compare_count <= compare_count + 1'b1;
            if (do_compare && differ && !(&error_count)) error_count <= error_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_output_checker.sv
// Randomized bench: a sample-log reference filter drives FIR_out, and a behavioural
// scoreboard predicts every checker output for a default instance and a stop-on-error one.
module tb_fir_output_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Sample_in = '0;
    logic        check_en = 1'b0;
    logic        inj_a = 1'b0, inj_b = 1'b0, late = 1'b0;

    logic [13:0] good_a, good_b, late_a;
    logic [13:0] fir_a, fir_b;
    logic [13:0] exp_a, exp_b;
    logic        mis_a, mis_b;
    logic [7:0]  err_a, err_b;
    logic [15:0] cmp_a, cmp_b;
    logic [1:0]  st_a, st_b;

    int checks = 0, failures = 0;

    always #5 clock = ~clock;

    assign fir_a = (late ? late_a : good_a) + {13'b0, inj_a};
    assign fir_b = good_b + {13'b0, inj_b};

    fir_output_checker dut_a (
        .clock(clock), .reset(reset), .Sample_in(Sample_in), .FIR_out(fir_a),
        .check_en(check_en), .expected_out(exp_a), .mismatch(mis_a),
        .error_count(err_a), .compare_count(cmp_a), .state(st_a)
    );

    fir_output_checker #(
        .W0(5'd31), .W1(5'd31), .W2(5'd31), .W3(5'd31), .W4(5'd31), .STOP_ON_ERROR(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .Sample_in(Sample_in), .FIR_out(fir_b),
        .check_en(check_en), .expected_out(exp_b), .mismatch(mis_b),
        .error_count(err_b), .compare_count(cmp_b), .state(st_b)
    );

    // ---------------- reference model ----------------
    int wts [2][5] = '{'{1, 2, 3, 4, 5}, '{31, 31, 31, 31, 31}};
    bit stop [2] = '{1'b0, 1'b1};
    int slog [$];
    int m_exp [2], m_mode [2], m_wc [2], m_err [2], m_cmp [2];
    bit m_mis [2];

    // Filter output for the sample captured two edges back (one edge of alignment).
    function automatic int filt(input int d);
        int s = 0;
        for (int k = 0; k < 5; k++) begin
            int idx = slog.size() - 2 - k;
            if (idx >= 0) s += wts[d][k] * slog[idx];
        end
        return s;
    endfunction

    task automatic step(input int d, input bit en, input int fir);
        m_mis[d] = 1'b0;
        case (m_mode[d])
            0: if (en) begin m_mode[d] = 1; m_wc[d] = 0; end
            1: if (!en) m_mode[d] = 0;
               else begin m_wc[d]++; if (m_wc[d] == 6) m_mode[d] = 2; end
            2: if (!en) m_mode[d] = 0;
               else begin
                   if (m_cmp[d] < 65535) m_cmp[d]++;
                   if (fir != m_exp[d]) begin
                       m_mis[d] = 1'b1;
                       if (m_err[d] < 255) m_err[d]++;
                       if (stop[d]) m_mode[d] = 3;
                   end
               end
            default: ;
        endcase
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            slog.delete();
            for (int d = 0; d < 2; d++) begin
                m_exp[d] = 0; m_mode[d] = 0; m_wc[d] = 0; m_err[d] = 0; m_cmp[d] = 0; m_mis[d] = 0;
            end
            good_a <= '0; good_b <= '0; late_a <= '0;
        end else begin
            bit was_halt [2];
            int ga, gb;
            for (int d = 0; d < 2; d++) was_halt[d] = (m_mode[d] == 3);
            step(0, check_en, int'(fir_a));
            step(1, check_en, int'(fir_b));
            slog.push_back(int'(Sample_in));
            if (slog.size() > 16) void'(slog.pop_front());
            ga = filt(0);
            gb = filt(1);
            if (!was_halt[0]) m_exp[0] = ga;
            if (!was_halt[1]) m_exp[1] = gb;
            good_a <= 14'(ga);
            good_b <= 14'(gb);
            late_a <= good_a;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clock) begin
        check("exp_a", int'(exp_a), m_exp[0]);
        check("mis_a", int'(mis_a), int'(m_mis[0]));
        check("err_a", int'(err_a), m_err[0]);
        check("cmp_a", int'(cmp_a), m_cmp[0]);
        check("state_a", int'(st_a), m_mode[0]);
        check("exp_b", int'(exp_b), m_exp[1]);
        check("mis_b", int'(mis_b), int'(m_mis[1]));
        check("err_b", int'(err_b), m_err[1]);
        check("cmp_b", int'(cmp_b), m_cmp[1]);
        check("state_b", int'(st_b), m_mode[1]);
    end

    // ---------------- stimulus ----------------
    task automatic rnd(input int n);
        repeat (n) begin
            @(negedge clock);
            Sample_in = 6'($urandom_range(0, 63));
        end
    endtask

    task automatic zeros(input int n);
        repeat (n) begin
            @(negedge clock);
            Sample_in = '0;
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_exp_a"}, int'(exp_a), 0);
        check({tag, "_err_a"}, int'(err_a), 0);
        check({tag, "_cmp_a"}, int'(cmp_a), 0);
        check({tag, "_mis_a"}, int'(mis_a), 0);
        check({tag, "_st_a"}, int'(st_a), 0);
        check({tag, "_exp_b"}, int'(exp_b), 0);
        check({tag, "_err_b"}, int'(err_b), 0);
        check({tag, "_st_b"}, int'(st_b), 0);
    endtask

    initial begin
        int imp [6] = '{1, 2, 3, 4, 5, 0};
        int pulses, held_err, held_cmp, frozen;

        #40;
        all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // enable: WARMUP for 6 edges, CHECK from the 7th
        @(negedge clock);
        check_en = 1'b1;
        repeat (6) @(negedge clock);
        check("warm_state", int'(st_a), 1);
        @(negedge clock);
        check("check_state", int'(st_a), 2);
        check("warm_err", int'(err_a), 0);

        // impulse
        zeros(6);
        @(negedge clock);
        Sample_in = 6'd1;
        @(negedge clock);
        Sample_in = 6'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("impulse", int'(exp_a), imp[i]);
        end

        rnd(150);

        // step to full scale
        @(negedge clock);
        Sample_in = 6'd63;
        repeat (8) @(negedge clock);
        check("step_945", int'(exp_a), 945);
        check("step_9765", int'(exp_b), 9765);
        check("step_err_a", int'(err_a), 0);

        // injected fault: 3 cycles on both instances
        rnd(5);
        pulses = 0;
        inj_a = 1'b1;
        inj_b = 1'b1;
        repeat (3) begin
            @(negedge clock);
            Sample_in = 6'($urandom_range(0, 63));
            pulses += int'(mis_a);
        end
        inj_a = 1'b0;
        inj_b = 1'b0;
        @(negedge clock);
        pulses += int'(mis_a);
        check("fault_pulses", pulses, 3);
        check("fault_err_a", int'(err_a), 3);
        check("halt_err_b", int'(err_b), 1);
        check("halt_state_b", int'(st_b), 3);
        frozen = int'(exp_b);
        rnd(6);
        check("halt_frozen", int'(exp_b), frozen);

        // filter one cycle later than the checker expects
        late = 1'b1;
        held_err = int'(err_a);
        foreach (imp[i]) begin
            @(negedge clock);
            Sample_in = (i == 0) ? 6'd1 : (i == 1) ? 6'd2 : (i == 2) ? 6'd8 : (i == 3) ? 6'd2 : (i == 4) ? 6'd1 : 6'd0;
        end
        zeros(6);
        check("latency_err", int'(int'(err_a) > held_err), 1);

        // drop enable mid-sequence
        @(negedge clock); Sample_in = 6'd1;
        @(negedge clock); Sample_in = 6'd2;
        @(negedge clock); Sample_in = 6'd8; check_en = 1'b0;
        @(negedge clock); Sample_in = 6'd2;
        check("idle_state", int'(st_a), 0);
        held_err = int'(err_a);
        held_cmp = int'(cmp_a);
        rnd(4);
        check("idle_err_hold", int'(err_a), held_err);
        check("idle_cmp_hold", int'(cmp_a), held_cmp);

        // re-enable and saturate the error counter
        late = 1'b0;
        @(negedge clock);
        check_en = 1'b1;
        rnd(8);
        inj_a = 1'b1;
        rnd(300);
        inj_a = 1'b0;
        @(negedge clock);
        check("sat_err", int'(err_a), 255);

        // asynchronous reset between clock edges
        @(posedge clock);
        #3 reset = 1'b1;
        #1 all_zero("async");
        @(negedge clock);
        reset = 1'b0;
        rnd(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
